// File: rtl/apb_gpio_bank_pkg.sv
// Shared definitions for the APB GPIO bank: register slot addresses,
// bus-handshake state encoding and wait-counter sizing.
package gpio_bank_pkg;

    localparam int unsigned ADDR_DIR      = 0;
    localparam int unsigned ADDR_OUT      = 1;
    localparam int unsigned ADDR_IN       = 2;
    localparam int unsigned ADDR_IRQ_EN   = 3;
    localparam int unsigned ADDR_IRQ_STAT = 4;
    localparam int unsigned ADDR_EDGE_SEL = 5;
    localparam int unsigned ADDR_OUT_TGL  = 6;
    localparam int unsigned ADDR_ID       = 7;

    // Holds any WAIT_STATES value in 0..15.
    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        HOLD
    } bus_state_t;

endpackage

// File: rtl/apb_gpio_bank_sync_edge.sv
// Pad input conditioning: two-flop synchronizer, previous-sample register
// and per-bit rising/falling edge detection.
module gpio_sync_edge #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pad,
    input  logic [WIDTH-1:0] edge_sel,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] edge_evt
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta   <= pad;
            sync_q <= meta;
            prev_q <= sync_q;
        end
    end

    // Selection happens after detection, so flipping edge_sel alone cannot
    // produce an event while sync and prev agree.
    always_comb begin
        edge_evt = (edge_sel & sync_q & ~prev_q) | (~edge_sel & ~sync_q & prev_q);
    end

    assign sync_in = sync_q;

endmodule

// File: rtl/apb_gpio_bank.sv
// APB register bank for one GPIO port: handshake FSM, register file,
// registered read data and level interrupt from latched edge status.
module apb_gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH  = 8,
    parameter int unsigned            ADDR_WIDTH  = 3,
    parameter int unsigned            WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0]  BANK_ID     = 'hA0
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    input  logic [DATA_WIDTH-1:0] gpio_in,
    output logic [DATA_WIDTH-1:0] gpio_out,
    output logic [DATA_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    bus_state_t state;
    bus_state_t state_next;

    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  write_q;

    logic                  access;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  acc_write;

    logic [DATA_WIDTH-1:0] dir_q;
    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] irq_en_q;
    logic [DATA_WIDTH-1:0] irq_stat_q;
    logic [DATA_WIDTH-1:0] edge_sel_q;
    logic [DATA_WIDTH-1:0] stat_clr;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [DATA_WIDTH-1:0] sync_in;
    logic [DATA_WIDTH-1:0] edge_evt;

    assign access = psel & penable;

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (WAIT_STATES == 0) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_next = IDLE;
                end else if (wait_cnt == WAIT_CNT_W'(WAIT_STATES - 1)) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end
            end
            RESP:    state_next = HOLD;
            HOLD:    if (!penable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                wait_cnt <= '0;
                if (access) begin
                    addr_q  <= paddr;
                    wdata_q <= pwdata;
                    write_q <= pwrite;
                end
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // With zero wait states the commit edge is the capture edge, so the live
    // bus fields are used instead of the not-yet-loaded captures.
    always_comb begin
        acc_addr  = (state == IDLE) ? paddr  : addr_q;
        acc_wdata = (state == IDLE) ? pwdata : wdata_q;
        acc_write = (state == IDLE) ? pwrite : write_q;
    end

    always_comb begin
        stat_clr = '0;
        if (commit && acc_write && (32'(acc_addr) == ADDR_IRQ_STAT)) begin
            stat_clr = acc_wdata;
        end
    end

    always_comb begin
        rd_val = '0;
        case (32'(acc_addr))
            ADDR_DIR:      rd_val = dir_q;
            ADDR_OUT:      rd_val = out_q;
            ADDR_IN:       rd_val = sync_in;
            ADDR_IRQ_EN:   rd_val = irq_en_q;
            ADDR_IRQ_STAT: rd_val = irq_stat_q;
            ADDR_EDGE_SEL: rd_val = edge_sel_q;
            ADDR_ID:       rd_val = BANK_ID;
            default:       rd_val = '0;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            dir_q      <= '0;
            out_q      <= '0;
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            edge_sel_q <= '0;
            prdata     <= '0;
        end else begin
            if (commit && acc_write) begin
                case (32'(acc_addr))
                    ADDR_DIR:      dir_q      <= acc_wdata;
                    ADDR_OUT:      out_q      <= acc_wdata;
                    ADDR_IRQ_EN:   irq_en_q   <= acc_wdata;
                    ADDR_EDGE_SEL: edge_sel_q <= acc_wdata;
                    ADDR_OUT_TGL:  out_q      <= out_q ^ acc_wdata;
                    default:       ;
                endcase
            end
            // Set after clear: a same-cycle event survives a W1C.
            irq_stat_q <= (irq_stat_q & ~stat_clr) | edge_evt;
            if (commit && !acc_write) begin
                prdata <= rd_val;
            end
        end
    end

    gpio_sync_edge #(
        .WIDTH (DATA_WIDTH)
    ) u_sync_edge (
        .clk      (pclk),
        .rst      (preset),
        .pad      (gpio_in),
        .edge_sel (edge_sel_q),
        .sync_in  (sync_in),
        .edge_evt (edge_evt)
    );

    assign pready   = (state == RESP);
    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = |(irq_stat_q & irq_en_q);

endmodule

// File: tb/tb_apb_gpio_bank.sv
// Two banks on a shared APB bus (0 and 3 wait states), checked against a
// transaction-level register model with randomized traffic.
module tb_apb_gpio_bank;

    localparam int WS1 = 3;

    logic       clk = 1'b0;
    logic       preset;
    logic [1:0] psel;
    logic       penable;
    logic       pwrite;
    logic [2:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] gpio_in;

    logic [7:0] rdata_b [2];
    logic       rdy_b   [2];
    logic [7:0] out_b   [2];
    logic [7:0] oe_b    [2];
    logic       irq_b   [2];

    int total = 0;
    int bad   = 0;

    int         ws   [2] = '{0, WS1};
    logic [7:0] ids  [2] = '{8'hA0, 8'hB1};
    logic [7:0] m_dir [2];
    logic [7:0] m_out [2];
    logic [7:0] m_en  [2];
    logic [7:0] m_stat[2];
    logic [7:0] m_esel[2];
    logic [7:0] m_last[2];
    logic [7:0] pads;

    always #5 clk = ~clk;

    apb_gpio_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .WAIT_STATES(0), .BANK_ID(8'hA0)) dut0 (
        .pclk(clk), .preset(preset), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(rdata_b[0]), .pready(rdy_b[0]),
        .gpio_in(gpio_in), .gpio_out(out_b[0]), .gpio_oe(oe_b[0]), .irq(irq_b[0])
    );

    apb_gpio_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .WAIT_STATES(WS1), .BANK_ID(8'hB1)) dut1 (
        .pclk(clk), .preset(preset), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(rdata_b[1]), .pready(rdy_b[1]),
        .gpio_in(gpio_in), .gpio_out(out_b[1]), .gpio_oe(oe_b[1]), .irq(irq_b[1])
    );

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_dir[b] = '0; m_out[b] = '0; m_en[b] = '0;
            m_stat[b] = '0; m_esel[b] = '0; m_last[b] = '0;
        end
    endtask

    function automatic logic [7:0] expect_read(input int b, input logic [2:0] a);
        case (a)
            3'd0:    return m_dir[b];
            3'd1:    return m_out[b];
            3'd2:    return pads;
            3'd3:    return m_en[b];
            3'd4:    return m_stat[b];
            3'd5:    return m_esel[b];
            3'd6:    return 8'h00;
            default: return ids[b];
        endcase
    endfunction

    task automatic model_write(input int b, input logic [2:0] a, input logic [7:0] d);
        case (a)
            3'd0: m_dir[b] = d;
            3'd1: m_out[b] = d;
            3'd3: m_en[b] = d;
            3'd4: m_stat[b] = m_stat[b] & ~d;
            3'd5: m_esel[b] = d;
            3'd6: m_out[b] = m_out[b] ^ d;
            default: ;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_pads(input logic [7:0] v);
        logic [7:0] rise, fall;
        rise = ~pads & v;
        fall = pads & ~v;
        for (int b = 0; b < 2; b++)
            m_stat[b] |= (rise & m_esel[b]) | (fall & ~m_esel[b]);
        pads    = v;
        gpio_in = v;
    endtask

    task automatic apb(input int b, input logic wr, input logic [2:0] a, input logic [7:0] d,
                       input logic [7:0] late_set = 8'h00);
        logic [7:0] exp_rd;
        logic       exp_irq;
        int         lat;
        bit         got;
        exp_rd = expect_read(b, a);
        psel = '0; psel[b] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 0; got = 0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (rdy_b[b] === 1'b1) got = 1;
        end
        total++;
        if (!got || lat != 1 + ws[b]) begin
            bad++;
            $display("FAIL latency bank%0d addr%0d: got=%0d cycles (seen=%0d) want=%0d", b, a, lat, got, 1 + ws[b]);
        end
        if (wr) begin
            model_write(b, a, d);
            m_stat[b] |= late_set;
            total++;
            if (rdata_b[b] !== m_last[b]) begin
                bad++;
                $display("FAIL prdata_hold bank%0d: got=%h want=%h", b, rdata_b[b], m_last[b]);
            end
        end else begin
            m_last[b] = exp_rd;
            total++;
            if (rdata_b[b] !== exp_rd) begin
                bad++;
                $display("FAIL read bank%0d addr%0d: got=%h want=%h", b, a, rdata_b[b], exp_rd);
            end
        end
        exp_irq = |(m_stat[b] & m_en[b]);
        total++;
        if (out_b[b] !== m_out[b] || oe_b[b] !== m_dir[b] || irq_b[b] !== exp_irq) begin
            bad++;
            $display("FAIL pins bank%0d: out=%h oe=%h irq=%b want out=%h oe=%h irq=%b",
                     b, out_b[b], oe_b[b], irq_b[b], m_out[b], m_dir[b], exp_irq);
        end
        psel = '0; penable = 1'b0;
        @(posedge clk); #1;
        total++;
        if (rdy_b[b] !== 1'b0) begin
            bad++;
            $display("FAIL pready_pulse bank%0d: got=%b want=0", b, rdy_b[b]);
        end
    endtask

    task automatic test_reset();
        preset = 1'b1;
        idle(3);
        preset = 1'b0;
        model_reset();
        for (int b = 0; b < 2; b++) begin
            total++;
            if (rdata_b[b] !== 8'h00 || rdy_b[b] !== 1'b0 || out_b[b] !== 8'h00 ||
                oe_b[b] !== 8'h00 || irq_b[b] !== 1'b0) begin
                bad++;
                $display("FAIL reset bank%0d: prdata=%h pready=%b out=%h oe=%h irq=%b want all 0",
                         b, rdata_b[b], rdy_b[b], out_b[b], oe_b[b], irq_b[b]);
            end
        end
        apb(0, 0, 3'd7, 8'h00);
        total++;
        if (rdata_b[0] !== 8'hA0) begin
            bad++;
            $display("FAIL id_read: got=%h want=a0", rdata_b[0]);
        end
    endtask

    task automatic test_out_toggle();
        apb(0, 1, 3'd0, 8'h0F);
        apb(0, 1, 3'd1, 8'h55);
        apb(0, 1, 3'd6, 8'h03);
        total++;
        if (oe_b[0] !== 8'h0F || out_b[0] !== 8'h56) begin
            bad++;
            $display("FAIL toggle_pins: oe=%h out=%h want oe=0f out=56", oe_b[0], out_b[0]);
        end
        apb(0, 0, 3'd1, 8'h00);
        apb(0, 0, 3'd6, 8'h00);
        apb(0, 1, 3'd7, 8'h5A);
        apb(0, 0, 3'd7, 8'h00);
    endtask

    task automatic test_hold();
        int  lat;
        bit  got;
        set_pads(8'hC3);
        idle(4);
        psel = 2'b10; penable = 1'b0; pwrite = 1'b0; paddr = 3'd2; pwdata = 8'h00;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 0; got = 0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (rdy_b[1] === 1'b1) got = 1;
        end
        total++;
        if (!got || lat != 4 || rdata_b[1] !== 8'hC3) begin
            bad++;
            $display("FAIL wait_read: lat=%0d seen=%0d prdata=%h want lat=4 prdata=c3", lat, got, rdata_b[1]);
        end
        m_last[1] = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (rdy_b[1] !== 1'b0) begin
                bad++;
                $display("FAIL hold_no_repeat cycle%0d: pready=%b want=0", i, rdy_b[1]);
            end
        end
        psel = '0; penable = 1'b0;
        idle(2);
    endtask

    task automatic test_edge_irq();
        apb(0, 1, 3'd5, 8'h01);
        apb(0, 1, 3'd3, 8'h03);
        set_pads(8'h02);
        idle(4);
        apb(0, 1, 3'd4, 8'hFF);
        idle(2);
        set_pads(8'h01);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            total++;
            if (irq_b[0] !== (c == 3)) begin
                bad++;
                $display("FAIL edge_latency cycle%0d: irq=%b want=%b", c, irq_b[0], (c == 3));
            end
        end
        idle(1);
        apb(0, 0, 3'd4, 8'h00);
        total++;
        if (rdata_b[0] !== 8'h03) begin
            bad++;
            $display("FAIL edge_stat: got=%h want=03", rdata_b[0]);
        end
        apb(0, 1, 3'd4, 8'h01);
        apb(0, 0, 3'd4, 8'h00);
        total++;
        if (rdata_b[0] !== 8'h02 || irq_b[0] !== 1'b1) begin
            bad++;
            $display("FAIL w1c_partial: stat=%h irq=%b want stat=02 irq=1", rdata_b[0], irq_b[0]);
        end
        apb(0, 1, 3'd5, 8'hFE);
        idle(4);
        apb(0, 0, 3'd4, 8'h00);
    endtask

    task automatic test_set_wins();
        apb(0, 1, 3'd5, 8'h01);
        set_pads(8'h03);
        idle(4);
        apb(0, 1, 3'd4, 8'h02);
        apb(0, 0, 3'd4, 8'h00);
        idle(2);
        set_pads(8'h01);
        @(posedge clk); #1;
        apb(0, 1, 3'd4, 8'h02, 8'h02);
        idle(2);
        apb(0, 0, 3'd4, 8'h00);
        total++;
        if (rdata_b[0][1] !== 1'b1) begin
            bad++;
            $display("FAIL set_wins: stat=%h want bit1=1", rdata_b[0]);
        end
    endtask

    task automatic test_abort();
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 3'd1; pwdata = 8'hAA;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = '0; penable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            total++;
            if (rdy_b[1] !== 1'b0 || out_b[1] !== m_out[1]) begin
                bad++;
                $display("FAIL abort cycle%0d: pready=%b out=%h want pready=0 out=%h", i, rdy_b[1], out_b[1], m_out[1]);
            end
        end
        apb(1, 0, 3'd1, 8'h00);
    endtask

    task automatic test_reset_mid();
        apb(1, 1, 3'd1, 8'h3C);
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 3'd1; pwdata = 8'hFF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        preset = 1'b1; psel = '0; penable = 1'b0;
        @(posedge clk); #1;
        preset = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            total++;
            if (rdy_b[1] !== 1'b0 || out_b[1] !== 8'h00) begin
                bad++;
                $display("FAIL reset_mid cycle%0d: pready=%b out=%h want pready=0 out=00", i, rdy_b[1], out_b[1]);
            end
            @(posedge clk); #1;
        end
        apb(1, 0, 3'd1, 8'h00);
    endtask

    task automatic test_random();
        int         b, op;
        logic [2:0] a;
        logic [7:0] d;
        for (int i = 0; i < 80; i++) begin
            b  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 9));
            a  = 3'($urandom_range(0, 7));
            d  = 8'($urandom);
            if (op < 4) begin
                apb(b, 1, a, d);
            end else if (op < 8) begin
                apb(b, 0, a, d);
            end else begin
                set_pads(d);
                idle(4);
            end
        end
        for (int bb = 0; bb < 2; bb++)
            for (int r = 0; r < 8; r++)
                apb(bb, 0, 3'(r), 8'h00);
    endtask

    initial begin
        preset = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; gpio_in = '0; pads = '0;
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_out_toggle();
        test_hold();
        test_edge_irq();
        test_set_wins();
        test_abort();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
